// File: rtl/core_wbu_pkg.sv
// core_wbu_pkg: shared writeback-unit encodings.
// Holds source codes, one-hot select positions, FSM states and XLEN default.
package core_wbu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] WB_SRC_NONE   = 3'd0;
    localparam logic [2:0] WB_SRC_IMME   = 3'd1;
    localparam logic [2:0] WB_SRC_PC     = 3'd2;
    localparam logic [2:0] WB_SRC_PC_SEQ = 3'd3;
    localparam logic [2:0] WB_SRC_CSR    = 3'd4;
    localparam logic [2:0] WB_SRC_MEM    = 3'd5;
    localparam logic [2:0] WB_SRC_ALU    = 3'd6;
    localparam logic [2:0] WB_SRC_RSVD   = 3'd7;

    localparam int WB_OH_W      = 6;
    localparam int WB_OH_IMME   = 0;
    localparam int WB_OH_PC     = 1;
    localparam int WB_OH_PC_SEQ = 2;
    localparam int WB_OH_CSR    = 3;
    localparam int WB_OH_MEM    = 4;
    localparam int WB_OH_ALU    = 5;

    typedef enum logic [1:0] {
        WBU_ST_IDLE     = 2'd0,
        WBU_ST_WAIT_MEM = 2'd1,
        WBU_ST_COMMIT   = 2'd2
    } wbu_state_e;

endpackage

// File: rtl/core_wbu_if.sv
// core_wbu_if: retire handshake from EXU/LSU plus GPR write port.
// slave = writeback unit side, master = upstream/GPR environment side.
interface core_wbu_if #(
    parameter int XLEN = core_wbu_pkg::XLEN_DEF
);
    logic            wbu_rx_valid;
    logic            wbu_rx_ready;
    logic [4:0]      wbu_rx_rd_idx;
    logic [2:0]      wbu_rx_src;
    logic [XLEN-1:0] wbu_rx_pc;
    logic [XLEN-1:0] wbu_rx_imme;
    logic [XLEN-1:0] wbu_rx_pc_seq;
    logic [XLEN-1:0] wbu_rx_csr;
    logic [XLEN-1:0] wbu_rx_exu_res;
    logic            wbu_rx_mem_valid;
    logic [XLEN-1:0] wbu_rx_mem_data;

    logic            wbu_tx_gpr_ready;
    logic [4:0]      wbu_tx_rd_idx;
    logic [XLEN-1:0] wbu_tx_imme;
    logic [XLEN-1:0] wbu_tx_pc;
    logic [XLEN-1:0] wbu_tx_pc_seq;
    logic [XLEN-1:0] wbu_tx_csr;
    logic [XLEN-1:0] wbu_tx_mem;
    logic [XLEN-1:0] wbu_tx_exu_res;
    logic            wbu_tx_imme_valid;
    logic            wbu_tx_pc_valid;
    logic            wbu_tx_pc_seq_valid;
    logic            wbu_tx_csr_valid;
    logic            wbu_tx_mem_valid;
    logic            wbu_tx_alu_valid;
    logic            wbu_tx_commit;
    logic [XLEN-1:0] wbu_tx_commit_pc;
    logic            wbu_tx_timeout;

    modport slave (
        input  wbu_rx_valid, wbu_rx_rd_idx, wbu_rx_src, wbu_rx_pc,
        input  wbu_rx_imme, wbu_rx_pc_seq, wbu_rx_csr, wbu_rx_exu_res,
        input  wbu_rx_mem_valid, wbu_rx_mem_data, wbu_tx_gpr_ready,
        output wbu_rx_ready, wbu_tx_rd_idx,
        output wbu_tx_imme, wbu_tx_pc, wbu_tx_pc_seq, wbu_tx_csr,
        output wbu_tx_mem, wbu_tx_exu_res,
        output wbu_tx_imme_valid, wbu_tx_pc_valid, wbu_tx_pc_seq_valid,
        output wbu_tx_csr_valid, wbu_tx_mem_valid, wbu_tx_alu_valid,
        output wbu_tx_commit, wbu_tx_commit_pc, wbu_tx_timeout
    );

    modport master (
        output wbu_rx_valid, wbu_rx_rd_idx, wbu_rx_src, wbu_rx_pc,
        output wbu_rx_imme, wbu_rx_pc_seq, wbu_rx_csr, wbu_rx_exu_res,
        output wbu_rx_mem_valid, wbu_rx_mem_data, wbu_tx_gpr_ready,
        input  wbu_rx_ready, wbu_tx_rd_idx,
        input  wbu_tx_imme, wbu_tx_pc, wbu_tx_pc_seq, wbu_tx_csr,
        input  wbu_tx_mem, wbu_tx_exu_res,
        input  wbu_tx_imme_valid, wbu_tx_pc_valid, wbu_tx_pc_seq_valid,
        input  wbu_tx_csr_valid, wbu_tx_mem_valid, wbu_tx_alu_valid,
        input  wbu_tx_commit, wbu_tx_commit_pc, wbu_tx_timeout
    );

endinterface

// File: rtl/core_wbu_src_dec.sv
// core_wbu_src_dec: 3-bit writeback source to one-hot GPR select.
// Ports: src_i (source code), rd_i (dest reg), oh_o (one-hot, zero when rd_i==0).
module core_wbu_src_dec
    import core_wbu_pkg::*;
(
    input  logic [2:0]         src_i,
    input  logic [4:0]         rd_i,
    output logic [WB_OH_W-1:0] oh_o
);

    // x0 is hardwired zero, so no write select is ever raised for it.
    always_comb begin
        oh_o = '0;
        if (rd_i != 5'd0) begin
            case (src_i)
                WB_SRC_IMME:   oh_o[WB_OH_IMME]   = 1'b1;
                WB_SRC_PC:     oh_o[WB_OH_PC]     = 1'b1;
                WB_SRC_PC_SEQ: oh_o[WB_OH_PC_SEQ] = 1'b1;
                WB_SRC_CSR:    oh_o[WB_OH_CSR]    = 1'b1;
                WB_SRC_MEM:    oh_o[WB_OH_MEM]    = 1'b1;
                WB_SRC_ALU:    oh_o[WB_OH_ALU]    = 1'b1;
                default:       oh_o               = '0;
            endcase
        end
    end

endmodule

// File: rtl/core_wbu.sv
// core_wbu: writeback unit, retires one instruction per handshake to the GPR.
// Ports: clk, rstn (async active-low), wbu (core_wbu_if.slave: rx handshake,
// load response, GPR write port, commit/trace, timeout). Optional load
// timeout enabled by defining CORE_WBU_TIMEOUT_EN.
module core_wbu
    import core_wbu_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rstn,
    core_wbu_if.slave wbu
);

    wbu_state_e         state_q;
    logic [4:0]         rd_q;
    logic [XLEN-1:0]    imme_q;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    pc_seq_q;
    logic [XLEN-1:0]    csr_q;
    logic [XLEN-1:0]    mem_q;
    logic [XLEN-1:0]    exu_q;
    logic [WB_OH_W-1:0] oh_q;
    logic               commit_q;
    logic               timeout_q;

    logic               rx_ready;
    logic               xfer;
    logic               is_load;
    logic               to_hit;
    logic [2:0]         dec_src;
    logic [4:0]         dec_rd;
    logic [WB_OH_W-1:0] dec_oh;

    assign rx_ready = rstn &&
        ((state_q == WBU_ST_IDLE) ||
         (state_q == WBU_ST_COMMIT && wbu.wbu_tx_gpr_ready));
    assign xfer    = wbu.wbu_rx_valid && rx_ready;
    assign is_load = (wbu.wbu_rx_src == WB_SRC_MEM);

    // While waiting, the selects come from the captured load, otherwise
    // from the instruction being handed over right now.
    assign dec_src = (state_q == WBU_ST_WAIT_MEM) ? WB_SRC_MEM : wbu.wbu_rx_src;
    assign dec_rd  = (state_q == WBU_ST_WAIT_MEM) ? rd_q : wbu.wbu_rx_rd_idx;

    core_wbu_src_dec u_src_dec (
        .src_i (dec_src),
        .rd_i  (dec_rd),
        .oh_o  (dec_oh)
    );

`ifdef CORE_WBU_TIMEOUT_EN
    localparam int TO_W =
        ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

    logic [TO_W-1:0] to_cnt_q;

    // Counter sits at zero outside WAIT_MEM, so each wait starts fresh.
    assign to_hit = (state_q == WBU_ST_WAIT_MEM) && !wbu.wbu_rx_mem_valid &&
                    (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != WBU_ST_WAIT_MEM) begin
                to_cnt_q <= '0;
            end else if (!wbu.wbu_rx_mem_valid) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (to_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_mem_timeout;

    assign unused_mem_timeout = (MEM_TIMEOUT != 0);
    assign to_hit             = 1'b0;
    assign timeout_q          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= WBU_ST_IDLE;
            rd_q     <= '0;
            imme_q   <= '0;
            pc_q     <= '0;
            pc_seq_q <= '0;
            csr_q    <= '0;
            mem_q    <= '0;
            exu_q    <= '0;
            oh_q     <= '0;
            commit_q <= 1'b0;
        end else if (xfer) begin
            rd_q     <= wbu.wbu_rx_rd_idx;
            imme_q   <= wbu.wbu_rx_imme;
            pc_q     <= wbu.wbu_rx_pc;
            pc_seq_q <= wbu.wbu_rx_pc_seq;
            csr_q    <= wbu.wbu_rx_csr;
            exu_q    <= wbu.wbu_rx_exu_res;
            if (!is_load || wbu.wbu_rx_mem_valid) begin
                state_q  <= WBU_ST_COMMIT;
                oh_q     <= dec_oh;
                commit_q <= 1'b1;
                if (is_load) begin
                    mem_q <= wbu.wbu_rx_mem_data;
                end
            end else begin
                state_q  <= WBU_ST_WAIT_MEM;
                oh_q     <= '0;
                commit_q <= 1'b0;
            end
        end else begin
            unique case (state_q)
                WBU_ST_WAIT_MEM: begin
                    if (wbu.wbu_rx_mem_valid || to_hit) begin
                        state_q  <= WBU_ST_COMMIT;
                        oh_q     <= dec_oh;
                        commit_q <= 1'b1;
                        mem_q    <= wbu.wbu_rx_mem_valid ?
                                    wbu.wbu_rx_mem_data : '0;
                    end
                end
                WBU_ST_COMMIT: begin
                    if (wbu.wbu_tx_gpr_ready) begin
                        state_q  <= WBU_ST_IDLE;
                        oh_q     <= '0;
                        commit_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wbu.wbu_rx_ready        = rx_ready;
    assign wbu.wbu_tx_rd_idx       = rd_q;
    assign wbu.wbu_tx_imme         = imme_q;
    assign wbu.wbu_tx_pc           = pc_q;
    assign wbu.wbu_tx_pc_seq       = pc_seq_q;
    assign wbu.wbu_tx_csr          = csr_q;
    assign wbu.wbu_tx_mem          = mem_q;
    assign wbu.wbu_tx_exu_res      = exu_q;
    assign wbu.wbu_tx_imme_valid   = oh_q[WB_OH_IMME];
    assign wbu.wbu_tx_pc_valid     = oh_q[WB_OH_PC];
    assign wbu.wbu_tx_pc_seq_valid = oh_q[WB_OH_PC_SEQ];
    assign wbu.wbu_tx_csr_valid    = oh_q[WB_OH_CSR];
    assign wbu.wbu_tx_mem_valid    = oh_q[WB_OH_MEM];
    assign wbu.wbu_tx_alu_valid    = oh_q[WB_OH_ALU];
    assign wbu.wbu_tx_commit       = commit_q;
    assign wbu.wbu_tx_commit_pc    = pc_q;
    assign wbu.wbu_tx_timeout      = timeout_q;

endmodule

// File: tb/tb_core_wbu.sv
// tb_core_wbu: self-checking bench for core_wbu.
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_core_wbu;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    core_wbu_if #(.XLEN(32)) bus ();

    core_wbu #(
        .XLEN        (32),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .wbu  (bus)
    );

    typedef struct {
        logic [2:0]  src;
        logic [4:0]  rd;
        logic [31:0] imme;
        logic [31:0] pc;
        logic [31:0] pc_seq;
        logic [31:0] csr;
        logic [31:0] exu;
        logic [31:0] mem;
    } ins_t;

    function automatic logic [5:0] obs_oh();
        return {bus.wbu_tx_alu_valid, bus.wbu_tx_mem_valid,
                bus.wbu_tx_csr_valid, bus.wbu_tx_pc_seq_valid,
                bus.wbu_tx_pc_valid, bus.wbu_tx_imme_valid};
    endfunction

    function automatic logic [236:0] obs_all();
        return {bus.wbu_tx_rd_idx, bus.wbu_tx_imme, bus.wbu_tx_pc,
                bus.wbu_tx_pc_seq, bus.wbu_tx_csr, bus.wbu_tx_mem,
                bus.wbu_tx_exu_res, obs_oh(), bus.wbu_tx_commit,
                bus.wbu_tx_commit_pc, bus.wbu_tx_timeout};
    endfunction

    // Source codes 1..6 map to select bits 0..5; x0 and none/reserved select nothing.
    function automatic logic [5:0] model_oh(input int src, input int rd);
        if (rd == 0 || src < 1 || src > 6) return 6'd0;
        return 6'(1 << (src - 1));
    endfunction

    task automatic rx_clear();
        bus.wbu_rx_valid     = 1'b0;
        bus.wbu_rx_src       = 3'd0;
        bus.wbu_rx_rd_idx    = 5'd0;
        bus.wbu_rx_pc        = 32'd0;
        bus.wbu_rx_imme      = 32'd0;
        bus.wbu_rx_pc_seq    = 32'd0;
        bus.wbu_rx_csr       = 32'd0;
        bus.wbu_rx_exu_res   = 32'd0;
        bus.wbu_rx_mem_valid = 1'b0;
        bus.wbu_rx_mem_data  = 32'd0;
        bus.wbu_tx_gpr_ready = 1'b1;
    endtask

    task automatic rx_put(input logic [2:0] src, input logic [4:0] rd,
                          input logic [31:0] pc, input logic [31:0] val);
        bus.wbu_rx_valid   = 1'b1;
        bus.wbu_rx_src     = src;
        bus.wbu_rx_rd_idx  = rd;
        bus.wbu_rx_pc      = pc;
        bus.wbu_rx_imme    = val;
        bus.wbu_rx_pc_seq  = val;
        bus.wbu_rx_csr     = val;
        bus.wbu_rx_exu_res = val;
    endtask

    task automatic test_reset();
        rx_clear();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.wbu_rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", bus.wbu_rx_ready);
        end
        n_checks++;
        if (obs_all() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs_all());
        end
        rstn = 1'b1;
        #1;
        n_checks++;
        if (bus.wbu_rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got %b expected 1", bus.wbu_rx_ready);
        end
    endtask

    task automatic test_alu();
        @(negedge clk);
        rx_put(3'd6, 5'd5, 32'h8000_0000, 32'h0000_1234);
        @(negedge clk);
        rx_clear();
        n_checks++;
        if ({obs_oh(), bus.wbu_tx_rd_idx, bus.wbu_tx_exu_res,
             bus.wbu_tx_commit, bus.wbu_tx_commit_pc} !==
            {6'b100000, 5'd5, 32'h1234, 1'b1, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL alu_commit: got oh=%b rd=%0d res=%h c=%b pc=%h expected oh=100000 rd=5 res=1234 c=1 pc=80000000",
                     obs_oh(), bus.wbu_tx_rd_idx, bus.wbu_tx_exu_res,
                     bus.wbu_tx_commit, bus.wbu_tx_commit_pc);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.wbu_tx_commit, obs_oh()} !== 7'd0) begin
            n_fail++;
            $display("FAIL alu_one_cycle: got c=%b oh=%b expected 0",
                     bus.wbu_tx_commit, obs_oh());
        end
    endtask

    task automatic test_load_delay();
        @(negedge clk);
        rx_put(3'd5, 5'd10, 32'h8000_0010, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) rx_clear();
            n_checks++;
            if ({bus.wbu_rx_ready, bus.wbu_tx_commit} !== 2'b00) begin
                n_fail++;
                $display("FAIL load_wait%0d: got ready=%b c=%b expected 0 0",
                         i, bus.wbu_rx_ready, bus.wbu_tx_commit);
            end
            if (i == 2) begin
                bus.wbu_rx_mem_valid = 1'b1;
                bus.wbu_rx_mem_data  = 32'hCAFE_F00D;
            end
        end
        @(negedge clk);
        bus.wbu_rx_mem_valid = 1'b0;
        n_checks++;
        if ({obs_oh(), bus.wbu_tx_mem, bus.wbu_tx_rd_idx,
             bus.wbu_tx_commit} !==
            {6'b010000, 32'hCAFE_F00D, 5'd10, 1'b1}) begin
            n_fail++;
            $display("FAIL load_commit: got oh=%b mem=%h rd=%0d c=%b expected oh=010000 mem=cafef00d rd=10 c=1",
                     obs_oh(), bus.wbu_tx_mem, bus.wbu_tx_rd_idx,
                     bus.wbu_tx_commit);
        end
        @(negedge clk);
        n_checks++;
        if (bus.wbu_tx_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: got c=%b expected 0", bus.wbu_tx_commit);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  srcs [3];
        logic [31:0] vals [3];
        logic [31:0] got;
        srcs = '{3'd1, 3'd3, 3'd4};
        vals = '{32'h10, 32'h84, 32'h300};
        @(negedge clk);
        rx_put(srcs[0], 5'd1, 32'h8000_0100, vals[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = (i == 0) ? bus.wbu_tx_imme :
                  (i == 1) ? bus.wbu_tx_pc_seq : bus.wbu_tx_csr;
            n_checks++;
            if ({obs_oh(), got, bus.wbu_tx_commit,
                 bus.wbu_tx_commit_pc} !==
                {model_oh(int'(srcs[i]), i + 1), vals[i], 1'b1,
                 32'h8000_0100 + 32'(4 * i)}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got oh=%b val=%h c=%b pc=%h expected oh=%b val=%h c=1",
                         i, obs_oh(), got, bus.wbu_tx_commit,
                         bus.wbu_tx_commit_pc,
                         model_oh(int'(srcs[i]), i + 1), vals[i]);
            end
            if (i < 2) begin
                rx_put(srcs[i+1], 5'(i + 2), 32'h8000_0100 + 32'(4 * (i + 1)),
                       vals[i+1]);
                #1;
                n_checks++;
                if (bus.wbu_rx_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready%0d: got %b expected 1",
                             i, bus.wbu_rx_ready);
                end
            end else begin
                rx_clear();
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.wbu_tx_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got c=%b expected 0", bus.wbu_tx_commit);
        end
    endtask

    task automatic test_rd_zero();
        logic [2:0] srcs [3];
        logic [4:0] rds  [3];
        srcs = '{3'd6, 3'd0, 3'd7};
        rds  = '{5'd0, 5'd3, 5'd4};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_put(srcs[i], rds[i], 32'h8000_0200, 32'h55AA_0000 + 32'(i));
            @(negedge clk);
            rx_clear();
            n_checks++;
            if ({bus.wbu_tx_commit, obs_oh()} !== 7'b1_000000) begin
                n_fail++;
                $display("FAIL novalid_%0d: got c=%b oh=%b expected c=1 oh=000000",
                         i, bus.wbu_tx_commit, obs_oh());
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
`ifdef CORE_WBU_TIMEOUT_EN
        @(negedge clk);
        rx_put(3'd5, 5'd9, 32'h8000_0300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) rx_clear();
            n_checks++;
            if ({bus.wbu_tx_commit, bus.wbu_rx_ready,
                 bus.wbu_tx_timeout} !== 3'b000) begin
                n_fail++;
                $display("FAIL to_wait%0d: got c=%b r=%b to=%b expected 0 0 0",
                         i, bus.wbu_tx_commit, bus.wbu_rx_ready,
                         bus.wbu_tx_timeout);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({bus.wbu_tx_commit, obs_oh(), bus.wbu_tx_mem,
             bus.wbu_tx_timeout} !== {1'b1, 6'b010000, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL to_commit: got c=%b oh=%b mem=%h to=%b expected 1 010000 0 1",
                     bus.wbu_tx_commit, obs_oh(), bus.wbu_tx_mem,
                     bus.wbu_tx_timeout);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.wbu_tx_timeout, bus.wbu_tx_commit} !== 2'b10) begin
            n_fail++;
            $display("FAIL to_sticky: got to=%b c=%b expected 1 0",
                     bus.wbu_tx_timeout, bus.wbu_tx_commit);
        end
`endif
    endtask

    task automatic test_backpressure_reset();
        @(negedge clk);
        rx_put(3'd6, 5'd7, 32'h8000_0040, 32'h0000_ABCD);
        @(negedge clk);
        rx_put(3'd1, 5'd8, 32'h8000_0050, 32'h0000_5555);
        bus.wbu_tx_gpr_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.wbu_rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready: got %b expected 0", bus.wbu_rx_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({obs_oh(), bus.wbu_tx_rd_idx, bus.wbu_tx_exu_res,
                 bus.wbu_tx_commit, bus.wbu_tx_commit_pc,
                 bus.wbu_rx_ready} !==
                {6'b100000, 5'd7, 32'hABCD, 1'b1, 32'h8000_0040, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got oh=%b rd=%0d res=%h c=%b pc=%h r=%b expected 100000 7 abcd 1 80000040 0",
                         i, obs_oh(), bus.wbu_tx_rd_idx, bus.wbu_tx_exu_res,
                         bus.wbu_tx_commit, bus.wbu_tx_commit_pc,
                         bus.wbu_rx_ready);
            end
        end
        rx_clear();
        @(negedge clk);
        n_checks++;
        if (bus.wbu_tx_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got c=%b expected 0", bus.wbu_tx_commit);
        end
        rx_put(3'd5, 5'd9, 32'h8000_0060, 32'h0);
        @(negedge clk);
        rx_clear();
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({bus.wbu_rx_ready, obs_all()} !== '0) begin
            n_fail++;
            $display("FAIL rst_midload: got r=%b out=%h expected 0",
                     bus.wbu_rx_ready, obs_all());
        end
        @(negedge clk);
        rstn = 1'b1;
        bus.wbu_rx_mem_valid = 1'b1;
        bus.wbu_rx_mem_data  = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.wbu_rx_mem_valid = 1'b0;
            n_checks++;
            if ({bus.wbu_tx_commit, obs_oh()} !== 7'd0) begin
                n_fail++;
                $display("FAIL rst_nocommit%0d: got c=%b oh=%b expected 0",
                         i, bus.wbu_tx_commit, obs_oh());
            end
        end
    endtask

    task automatic test_random();
        ins_t q[$];
        ins_t ni;
        bit   have_data = 1'b0;
        int   waitc     = 0;
        bit   exp_commit, exp_ready, waiting, xfer;
        rx_clear();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            exp_commit = (q.size() != 0) && have_data;
            n_checks++;
            if (bus.wbu_tx_commit !== exp_commit) begin
                n_fail++;
                $display("FAIL rnd_commit@%0d: got %b expected %b",
                         cyc, bus.wbu_tx_commit, exp_commit);
            end
            if (exp_commit) begin
                n_checks++;
                if ({obs_oh(), bus.wbu_tx_rd_idx, bus.wbu_tx_imme,
                     bus.wbu_tx_pc, bus.wbu_tx_pc_seq, bus.wbu_tx_csr,
                     bus.wbu_tx_exu_res, bus.wbu_tx_commit_pc} !==
                    {model_oh(int'(q[0].src), int'(q[0].rd)), q[0].rd,
                     q[0].imme, q[0].pc, q[0].pc_seq, q[0].csr,
                     q[0].exu, q[0].pc}) begin
                    n_fail++;
                    $display("FAIL rnd_fields@%0d: got oh=%b rd=%0d pc=%h expected oh=%b rd=%0d pc=%h src=%0d",
                             cyc, obs_oh(), bus.wbu_tx_rd_idx, bus.wbu_tx_pc,
                             model_oh(int'(q[0].src), int'(q[0].rd)),
                             q[0].rd, q[0].pc, q[0].src);
                end
                if (q[0].src == 3'd5) begin
                    n_checks++;
                    if (bus.wbu_tx_mem !== q[0].mem) begin
                        n_fail++;
                        $display("FAIL rnd_mem@%0d: got %h expected %h",
                                 cyc, bus.wbu_tx_mem, q[0].mem);
                    end
                end
            end else begin
                n_checks++;
                if (obs_oh() !== 6'd0) begin
                    n_fail++;
                    $display("FAIL rnd_idle_oh@%0d: got %b expected 0",
                             cyc, obs_oh());
                end
            end
            waiting = (q.size() != 0) && !have_data;
            bus.wbu_rx_valid     = ($urandom_range(0, 3) != 0);
            bus.wbu_rx_src       = 3'($urandom_range(0, 7));
            bus.wbu_rx_rd_idx    = 5'($urandom_range(0, 31));
            bus.wbu_rx_pc        = $urandom;
            bus.wbu_rx_imme      = $urandom;
            bus.wbu_rx_pc_seq    = $urandom;
            bus.wbu_rx_csr       = $urandom;
            bus.wbu_rx_exu_res   = $urandom;
            bus.wbu_rx_mem_data  = $urandom;
            bus.wbu_rx_mem_valid = ($urandom_range(0, 2) == 0) ||
                                   (waiting && waitc >= 2);
            bus.wbu_tx_gpr_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (q.size() == 0) || (have_data && bus.wbu_tx_gpr_ready);
            n_checks++;
            if (bus.wbu_rx_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rnd_ready@%0d: got %b expected %b",
                         cyc, bus.wbu_rx_ready, exp_ready);
            end
            xfer = bus.wbu_rx_valid && exp_ready;
            if (q.size() != 0) begin
                if (!have_data) begin
                    if (bus.wbu_rx_mem_valid) begin
                        q[0].mem  = bus.wbu_rx_mem_data;
                        have_data = 1'b1;
                    end else begin
                        waitc++;
                    end
                end else if (bus.wbu_tx_gpr_ready) begin
                    void'(q.pop_front());
                end
            end
            if (xfer) begin
                ni.src    = bus.wbu_rx_src;
                ni.rd     = bus.wbu_rx_rd_idx;
                ni.imme   = bus.wbu_rx_imme;
                ni.pc     = bus.wbu_rx_pc;
                ni.pc_seq = bus.wbu_rx_pc_seq;
                ni.csr    = bus.wbu_rx_csr;
                ni.exu    = bus.wbu_rx_exu_res;
                ni.mem    = (q.size() != 0) ? q[0].mem : 32'd0;
                if (ni.src == 3'd5) begin
                    have_data = bus.wbu_rx_mem_valid;
                    ni.mem    = bus.wbu_rx_mem_data;
                end else begin
                    have_data = 1'b1;
                end
                waitc = 0;
                q.push_back(ni);
            end
        end
        rx_clear();
`ifndef CORE_WBU_TIMEOUT_EN
        n_checks++;
        if (bus.wbu_tx_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_timeout_tied: got %b expected 0",
                     bus.wbu_tx_timeout);
        end
`endif
    endtask

    initial begin
        rx_clear();
        test_reset();
        test_alu();
        test_load_delay();
        test_back_to_back();
        test_rd_zero();
        test_timeout();
        test_backpressure_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
